deemphasis_iir: RTL and testbench



---
 rtl/deemphasis_iir.sv | 138 +++++++++++++
 tb/tb_deemphasis_iir.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deemphasis_iir.sv
// Single-pole IIR de-emphasis: y[n] = DEQ(X0*x[n]) + DEQ(X1*x[n-1]) + DEQ(Y1*y[n-1]) on one shared multiplier.
// Optional output clamping with `define IIR_SATURATE_EN; otherwise the accumulator wraps to DATA_WIDTH bits.
module deemphasis_iir #(
  parameter int                            DATA_WIDTH = 32,
  parameter int                            BITS       = 10,
  parameter logic signed [DATA_WIDTH-1:0]  X0         = 179,
  parameter logic signed [DATA_WIDTH-1:0]  X1         = 179,
  parameter logic signed [DATA_WIDTH-1:0]  Y1         = -665
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = DATA_WIDTH + 2;
  localparam logic signed [PW-1:0] RND = signed'({{(PW-BITS){1'b0}}, {BITS{1'b1}}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                       state_reg, state_next;
  logic signed [DATA_WIDTH-1:0] x_reg, x_next;
  logic signed [DATA_WIDTH-1:0] x1_reg, x1_next;
  logic signed [DATA_WIDTH-1:0] y1_reg, y1_next;
  logic signed [AW-1:0]         acc_reg, acc_next;
  logic [1:0]                   tap_reg, tap_next;

  logic signed [DATA_WIDTH-1:0] coef, operand, y;
  logic signed [PW-1:0]         prod, prod_adj;
  logic signed [DATA_WIDTH-1:0] deq;
  logic signed [AW-1:0]         term;

  always_comb begin
    coef    = Y1;
    operand = y1_reg;
    case (tap_reg)
      2'd0: begin coef = X0; operand = x_reg;  end
      2'd1: begin coef = X1; operand = x1_reg; end
      default: ;
    endcase
  end

  // Bias negative products so the arithmetic shift rounds toward zero.
  assign prod     = PW'(coef) * PW'(operand);
  assign prod_adj = prod[PW-1] ? prod + RND : prod;
  assign deq      = prod_adj[BITS +: DATA_WIDTH];
  assign term     = AW'(deq);

`ifdef IIR_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    if (acc_reg > SAT_MAX)
      y = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc_reg < SAT_MIN)
      y = SAT_MIN[DATA_WIDTH-1:0];
    else
      y = acc_reg[DATA_WIDTH-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{prod_adj[PW-1:BITS+DATA_WIDTH], prod_adj[BITS-1:0]};
`else
  assign y = acc_reg[DATA_WIDTH-1:0];

  logic unused_bits;
  assign unused_bits = ^{prod_adj[PW-1:BITS+DATA_WIDTH], prod_adj[BITS-1:0], acc_reg[AW-1:DATA_WIDTH]};
`endif

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    x1_next    = x1_reg;
    y1_next    = y1_reg;
    acc_next   = acc_reg;
    tap_next   = tap_reg;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = '0;
    case (state_reg)
      S_IDLE: begin
        // reset_n gate keeps the pop strobe low while reset is held
        if (!in_empty && reset_n) begin
          in_rd_en   = 1'b1;
          x_next     = in_dout;
          acc_next   = '0;
          tap_next   = 2'd0;
          state_next = S_MAC;
        end
      end
      S_MAC: begin
        acc_next = acc_reg + term;
        tap_next = tap_reg + 2'd1;
        if (tap_reg >= 2'd2)
          state_next = S_OUT;
      end
      S_OUT: begin
        out_din = y;
        if (!out_full) begin
          out_wr_en  = 1'b1;
          x1_next    = x_reg;
          y1_next    = y;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      acc_reg   <= '0;
      tap_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      x1_reg    <= x1_next;
      y1_reg    <= y1_next;
      acc_reg   <= acc_next;
      tap_reg   <= tap_next;
    end
  end

endmodule

// File: tb/tb_deemphasis_iir.sv
// Scoreboard bench for deemphasis_iir: directed vectors with hand-computed results, plus a truncating-division model.
`timescale 1ns/1ps
module tb_deemphasis_iir;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_dout, out_din;
  logic         in_empty, in_rd_en, out_full, out_wr_en;
  logic [W-1:0] ov_dout, ov_din;
  logic         ov_empty, ov_rd, ov_full, ov_wr;

  always #5 clock = ~clock;

  deemphasis_iir dut (
    .clock(clock), .reset_n(reset_n),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en)
  );

  deemphasis_iir #(.X0(1024), .X1(1024), .Y1(0)) dut_ov (
    .clock(clock), .reset_n(reset_n),
    .in_dout(ov_dout), .in_empty(ov_empty), .in_rd_en(ov_rd),
    .out_din(ov_din), .out_full(ov_full), .out_wr_en(ov_wr)
  );

  int n_vec = 0;
  int n_err = 0;
  int in_q[$];
  int exp_q[$];
  bit starve_en = 1'b0;
  int cycle = 0;
  int last_wr = -100;
  int wr_count = 0;
  int pops = 0;
  int mx1 = 0;
  int my1 = 0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(req));
    end
  endtask

  // SV integer division truncates toward zero, matching the filter's rounding rule.
  function automatic int deq(input longint p);
    return int'(p / 1024);
  endfunction

  task automatic send(input int x, input int e);
    in_q.push_back(x);
    exp_q.push_back(e);
    mx1 = x;
    my1 = e;
  endtask

  task automatic send_model(input int x);
    int e;
    e = deq(179 * longint'(x)) + deq(179 * longint'(mx1)) + deq(-665 * longint'(my1));
    send(x, e);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && c < budget) begin
      @(negedge clock);
      c++;
    end
    repeat (2) @(negedge clock);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic wait_pop(input int target);
    int c = 0;
    while (pops < target && c < 200) begin
      @(negedge clock);
      c++;
    end
    n_vec++;
    if (pops < target) begin
      n_err++;
      $display("FAIL pop_timeout pops=%0d required=%0d", pops, target);
    end
  endtask

  // Input FIFO model: first-word-fall-through, optional random starvation.
  initial begin
    bit pop;
    in_empty = 1'b1;
    in_dout  = '0;
    forever begin
      @(negedge clock);
      if (in_q.size() > 0 && !(starve_en && $urandom_range(0, 1) == 0)) begin
        in_empty = 1'b0;
        in_dout  = in_q[0];
      end else begin
        in_empty = 1'b1;
        in_dout  = 32'hDEADBEEF;
      end
      #1;
      pop = in_rd_en;
      @(posedge clock);
      if (pop) begin
        void'(in_q.pop_front());
        pops++;
      end
    end
  end

  // Monitor: pops the scoreboard on every output write.
  initial begin
    int e;
    forever begin
      @(negedge clock);
      #2;
      if (in_rd_en && out_wr_en) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_wr_overlap actual=both required=exclusive");
      end
      if (out_wr_en) begin
        wr_count++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write actual=%0d required=no_write", $signed(out_din));
        end else begin
          e = exp_q.pop_front();
          $display("wr cycle=%0d out_din=%0d expected=%0d", cycle, $signed(out_din), e);
          if ($signed(out_din) !== e) begin
            n_err++;
            $display("FAIL out_din actual=%0d required=%0d", $signed(out_din), e);
          end
        end
        n_vec++;
        if (cycle - last_wr < 5) begin
          n_err++;
          $display("FAIL write_spacing actual=%0d required>=5", cycle - last_wr);
        end
        last_wr = cycle;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0, ov_pops, ov_wr_n;
    logic [W-1:0] ov_exp[2];
    reset_n  = 1'b0;
    out_full = 1'b0;
    ov_empty = 1'b1;
    ov_full  = 1'b0;
    ov_dout  = '0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_out_din", out_din, '0);
    chk("reset_wr_en", {31'd0, out_wr_en}, '0);
    chk("reset_rd_en", {31'd0, in_rd_en}, '0);
    @(negedge clock);
    reset_n = 1'b1;

    // impulse response
    send(1024, 179);
    send(0, 63);
    send(0, -40);
    drain(200);

    // cold reset, then a negative input that rounds to zero
    @(negedge clock);
    reset_n = 1'b0;
    mx1 = 0; my1 = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    last_wr = -100;
    send(-1, 0);
    drain(200);

    // backpressure: hold out_full for 10 cycles in S_OUT with more input waiting
    out_full = 1'b1;
    p0 = pops;
    send(2048, 358);
    send(0, 126);
    wait_pop(p0 + 1);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_wr_en", {31'd0, out_wr_en}, '0);
      chk("bp_rd_en", {31'd0, in_rd_en}, '0);
      chk("bp_out_din", out_din, 32'd358);
      @(negedge clock);
    end
    w0 = wr_count;
    out_full = 1'b0;
    repeat (4) @(negedge clock);
    #3;
    chk("bp_single_write", wr_count - w0, 32'd1);
    drain(200);

    // input starvation against the model
    starve_en = 1'b1;
    for (int i = 0; i < 20; i++)
      send_model(int'($urandom_range(0, 200000)) - 100000);
    drain(3000);
    starve_en = 1'b0;

    // reset in the middle of a MAC discards the sample and history
    p0 = pops;
    in_q.push_back(777);
    wait_pop(p0 + 1);
    @(negedge clock);
    reset_n = 1'b0;
    mx1 = 0; my1 = 0;
    #1;
    chk("rst_mac_out_din", out_din, '0);
    chk("rst_mac_wr_en", {31'd0, out_wr_en}, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("rst_hold_wr_en", {31'd0, out_wr_en}, '0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    last_wr = -100;
    send(1024, 179);
    send(0, 63);
    drain(200);

    // overflow on the unity-gain instance
    ov_exp[0] = 32'h7FFFFFFF;
`ifdef IIR_SATURATE_EN
    ov_exp[1] = 32'h7FFFFFFF;
`else
    ov_exp[1] = 32'hFFFFFFFE;
`endif
    ov_dout = 32'h7FFFFFFF;
    ov_pops = 0;
    ov_wr_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      ov_empty = (ov_pops >= 2);
      #1;
      if (ov_rd) ov_pops++;
      if (ov_wr) begin
        $display("ov wr cycle=%0d out_din=%08h expected=%08h", cycle, ov_din, ov_exp[ov_wr_n % 2]);
        chk("ov_out_din", ov_din, ov_exp[ov_wr_n % 2]);
        ov_wr_n++;
      end
    end
    chk("ov_write_count", ov_wr_n, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
